dpram_mailbox: RTL and testbench

Parametrised shared-memory mailbox between the J1 I/O bus and one core peripheral. It is the successor to the plain dual-port RAM plus peripheral pairing. It adds:
- configurable data and address widths;
- memory-mapped CTRL/STATUS registers;
- a start/done ownership handshake that arbitrates the buffer between CPU and peripheral;
- a busy timeout and an interrupt.

The CPU fills the buffer, starts the peripheral, and collects results after done or interrupt.

---
 rtl/dpram_mailbox.sv | 202 ++++++++++++++++++++
 tb/tb_dpram_mailbox.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_mailbox.sv
// Shared-memory mailbox between the J1 I/O bus and one peripheral: dual-port buffer
// plus CTRL/STATUS registers and a start/done ownership handshake with busy timeout.
module dpram_mailbox #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic              p_rd,
  input  logic              p_wr,
  input  logic [DATA_W-1:0] p_d_in,
  output logic [DATA_W-1:0] p_d_out,
  output logic              p_start,
  input  logic              p_done,
  output logic              irq
);
  localparam int DEPTH = (2 ** ADDR_W) - 2;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  state_t            state_q, state_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic              tmo_q, tmo_d;
  logic              irq_en_q, irq_en_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic [DATA_W-1:0] p_d_out_q, p_d_out_d;
  logic              p_start_q, p_start_d;
  logic              irq_q, irq_d;

  logic              cpu_rd_s, cpu_wr_s, cpu_buf_s, p_buf_s, busy_s;
  logic              ctrl_wr_s, stat_rd_s, start_any_s, start_req_s, drop_viol_s;
  logic              mem_cpu_we_s, mem_p_we_s;
  logic [DATA_W-1:0] status_s;

  assign cpu_rd_s     = cs & rd;
  assign cpu_wr_s     = cs & wr;
  assign cpu_buf_s    = (addr < STATUS_ADDR);
  assign p_buf_s      = (p_addr < STATUS_ADDR);
  assign busy_s       = (state_q == ST_START) || (state_q == ST_BUSY);
  assign ctrl_wr_s    = cpu_wr_s && (addr == CTRL_ADDR);
  assign stat_rd_s    = cpu_rd_s && (addr == STATUS_ADDR);
  assign start_any_s  = ctrl_wr_s & d_in[0];
  assign start_req_s  = start_any_s & ~busy_s;
  // The peripheral owns buffer writes while busy; the CPU owns them otherwise.
  assign mem_cpu_we_s = rst_n & cpu_wr_s & cpu_buf_s & ~busy_s;
  assign mem_p_we_s   = rst_n & p_wr & p_buf_s & busy_s;
  assign drop_viol_s  = (cpu_wr_s & cpu_buf_s & busy_s) | (p_wr & p_buf_s & ~busy_s) |
                        (start_any_s & busy_s);

  // STATUS word assembly
  always_comb begin
    status_s      = '0;
    status_s[4:0] = {irq_en_q, tmo_q, drop_q, done_q, busy_s};
  end

  // Next-state logic for the FSM, flags and read data
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    d_out_d   = d_out_q;
    p_d_out_d = p_d_out_q;

    if (cpu_rd_s) begin
      if (cpu_buf_s) begin
        d_out_d = mem_q[addr];
      end else if (addr == STATUS_ADDR) begin
        d_out_d = status_s;
      end else begin
        d_out_d = '0;
      end
    end else begin
      d_out_d = d_out_q;
    end

    if (p_rd) begin
      if (p_buf_s) begin
        p_d_out_d = mem_q[p_addr];
      end else begin
        p_d_out_d = '0;
      end
    end else begin
      p_d_out_d = p_d_out_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_req_s) begin
          state_d = ST_START;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
        end else if ((state_q == ST_DONE) && stat_rd_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_START: begin
        state_d = ST_BUSY;
        cnt_d   = '0;
      end
      ST_BUSY: begin
        // p_done takes priority over a coincident timeout
        if (p_done) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ctrl_wr_s) begin
      irq_en_d = d_in[1];
    end else begin
      irq_en_d = irq_en_q;
    end

    if (drop_viol_s) begin
      drop_d = 1'b1;
    end else if (ctrl_wr_s && d_in[2]) begin
      drop_d = 1'b0;
    end else begin
      drop_d = drop_q;
    end

    p_start_d = (state_d == ST_START);
    irq_d     = done_d & irq_en_d;
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      tmo_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      cnt_q     <= '0;
      d_out_q   <= '0;
      p_d_out_q <= '0;
      p_start_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
      tmo_q     <= tmo_d;
      irq_en_q  <= irq_en_d;
      cnt_q     <= cnt_d;
      d_out_q   <= d_out_d;
      p_d_out_q <= p_d_out_d;
      p_start_q <= p_start_d;
      irq_q     <= irq_d;
    end
  end

  // Buffer write ports (contents are not reset)
  always_ff @(posedge clk) begin
    if (mem_cpu_we_s) begin
      mem_q[addr] <= d_in;
    end
    if (mem_p_we_s) begin
      mem_q[p_addr] <= p_d_in;
    end
  end

  assign d_out   = d_out_q;
  assign p_d_out = p_d_out_q;
  assign p_start = p_start_q;
  assign irq     = irq_q;
endmodule

// File: tb/tb_dpram_mailbox.sv
// Self-checking bench for dpram_mailbox: directed scenarios plus randomized traffic
// compared against a cycle-numbered behavioural model of the mailbox.
module tb_dpram_mailbox;
  localparam int TO    = 8;
  localparam int DEPTH = 254;
  localparam logic [7:0] A_STAT = 8'd254;
  localparam logic [7:0] A_CTRL = 8'd255;

  logic        clk, rst_n, cs, rd, wr, p_rd, p_wr, p_done;
  logic [7:0]  addr, p_addr;
  logic [15:0] d_in, p_d_in, d_out, p_d_out;
  logic        p_start, irq;

  dpram_mailbox #(.DATA_W(16), .ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .rd(rd), .wr(wr), .d_in(d_in),
    .d_out(d_out), .p_addr(p_addr), .p_rd(p_rd), .p_wr(p_wr), .p_d_in(p_d_in),
    .p_d_out(p_d_out), .p_start(p_start), .p_done(p_done), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: buffer contents plus the flags, with done/timeout derived
  // from the edge number at which start was accepted.
  logic [15:0] m_mem [0:DEPTH-1];
  bit          m_val [0:DEPTH-1];
  bit          m_busy, m_done, m_drop, m_tmo, m_ien, m_pstart;
  int          cyc, t0;
  logic [15:0] exp_d, exp_pd;
  bit          exp_d_ok, exp_pd_ok;
  int          checks, errors;

  function automatic logic [15:0] model_status();
    return {11'd0, m_ien, m_tmo, m_drop, m_done, m_busy};
  endfunction

  task automatic tick();
    logic [15:0] st;
    bit own_p, n_busy, n_done, n_drop, n_tmo, n_ien, n_ps;
    int edge_n;
    st = model_status();
    own_p = m_busy;
    edge_n = cyc + 1;
    n_busy = m_busy; n_done = m_done; n_drop = m_drop; n_tmo = m_tmo; n_ien = m_ien; n_ps = 1'b0;
    if (!rst_n) begin
      n_busy = 0; n_done = 0; n_drop = 0; n_tmo = 0; n_ien = 0;
      exp_d = 16'h0000; exp_pd = 16'h0000; exp_d_ok = 1; exp_pd_ok = 1;
    end else begin
      if (cs && rd) begin
        if (addr < A_STAT) begin exp_d = m_mem[addr]; exp_d_ok = m_val[addr]; end
        else if (addr == A_STAT) begin exp_d = st; exp_d_ok = 1; if (m_done) n_done = 0; end
        else begin exp_d = 16'h0000; exp_d_ok = 1; end
      end
      if (p_rd) begin
        if (p_addr < A_STAT) begin exp_pd = m_mem[p_addr]; exp_pd_ok = m_val[p_addr]; end
        else begin exp_pd = 16'h0000; exp_pd_ok = 1; end
      end
      if (m_busy && edge_n >= t0 + 2) begin
        if (p_done) begin n_busy = 0; n_done = 1; end
        else if (edge_n == t0 + 1 + TO) begin n_busy = 0; n_done = 1; n_tmo = 1; end
      end
      if (cs && wr) begin
        if (addr < A_STAT) begin
          if (own_p) n_drop = 1;
          else begin m_mem[addr] = d_in; m_val[addr] = 1; end
        end else if (addr == A_CTRL) begin
          n_ien = d_in[1];
          if (d_in[2]) n_drop = 0;
          if (d_in[0]) begin
            if (own_p) n_drop = 1;
            else begin n_busy = 1; n_done = 0; n_tmo = 0; n_ps = 1; t0 = edge_n; end
          end
        end
      end
      if (p_wr && p_addr < A_STAT) begin
        if (!own_p) n_drop = 1;
        else begin m_mem[p_addr] = p_d_in; m_val[p_addr] = 1; end
      end
    end
    @(posedge clk);
    #1;
    cyc = edge_n;
    m_busy = n_busy; m_done = n_done; m_drop = n_drop; m_tmo = n_tmo; m_ien = n_ien; m_pstart = n_ps;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [15:0] d);
    cs = 1; wr = 1; addr = a; d_in = d; tick(); cs = 0; wr = 0;
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    cs = 1; rd = 1; addr = a; tick(); cs = 0; rd = 0;
  endtask

  task automatic per_wr(input logic [7:0] a, input logic [15:0] d);
    p_wr = 1; p_addr = a; p_d_in = d; tick(); p_wr = 0;
  endtask

  task automatic per_rd(input logic [7:0] a);
    p_rd = 1; p_addr = a; tick(); p_rd = 0;
  endtask

  task automatic pulse_done();
    p_done = 1; tick(); p_done = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(2); rst_n = 1;
    checks++;
    if (d_out !== 16'h0000 || p_d_out !== 16'h0000 || irq !== 1'b0 || p_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: d_out=%h p_d_out=%h irq=%b p_start=%b, required all zero", d_out, p_d_out, irq, p_start);
    end
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0000) begin errors++; $display("FAIL reset_status: got %h want 0000", d_out); end
  endtask

  task automatic test_cpu_loop();
    logic [7:0] a;
    cpu_wr(8'd5, 16'h1234);
    cpu_rd(8'd5);
    checks++;
    if (d_out !== 16'h1234) begin errors++; $display("FAIL cpu_loop: got %h want 1234", d_out); end
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(8, 253));
      cpu_wr(a, 16'($urandom()));
      cpu_rd(a);
      checks++;
      if (d_out !== exp_d) begin errors++; $display("FAIL cpu_rand_rw[%0d]: got %h want %h", a, d_out, exp_d); end
      per_rd(a);
      checks++;
      if (p_d_out !== exp_pd) begin errors++; $display("FAIL per_rand_rd[%0d]: got %h want %h", a, p_d_out, exp_pd); end
    end
  endtask

  task automatic test_handshake();
    cpu_wr(A_CTRL, 16'h0003);
    checks++;
    if (p_start !== 1'b1) begin errors++; $display("FAIL hs_pstart_hi: got %b want 1", p_start); end
    idle(1);
    checks++;
    if (p_start !== 1'b0) begin errors++; $display("FAIL hs_pstart_lo: got %b want 0", p_start); end
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0011) begin errors++; $display("FAIL hs_status_busy: got %h want 0011", d_out); end
    per_rd(8'd5);
    checks++;
    if (p_d_out !== 16'h1234) begin errors++; $display("FAIL hs_per_read: got %h want 1234", p_d_out); end
    per_wr(8'd6, 16'hBEEF);
    pulse_done();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL hs_irq_set: got %b want 1", irq); end
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0012) begin errors++; $display("FAIL hs_status_done: got %h want 0012", d_out); end
    cpu_rd(8'd6);
    checks++;
    if (d_out !== 16'hBEEF) begin errors++; $display("FAIL hs_cpu_read: got %h want beef", d_out); end
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0010 || irq !== 1'b0) begin
      errors++; $display("FAIL hs_status_after: got %h irq=%b want 0010 irq=0", d_out, irq);
    end
  endtask

  task automatic test_ownership();
    cpu_wr(8'd7, 16'h7777);
    cpu_wr(A_CTRL, 16'h0003);
    idle(1);
    cpu_wr(8'd6, 16'hAAAA);
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0015) begin errors++; $display("FAIL own_cpu_drop: got %h want 0015", d_out); end
    cpu_wr(A_CTRL, 16'h0006);
    cpu_wr(A_CTRL, 16'h0003);
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0015) begin errors++; $display("FAIL own_restart_drop: got %h want 0015", d_out); end
    pulse_done();
    cpu_rd(8'd6);
    checks++;
    if (d_out !== 16'hBEEF) begin errors++; $display("FAIL own_mem_kept: got %h want beef", d_out); end
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0016) begin errors++; $display("FAIL own_status_done: got %h want 0016", d_out); end
    per_wr(8'd7, 16'h5555);
    cpu_rd(8'd7);
    checks++;
    if (d_out !== 16'h7777) begin errors++; $display("FAIL own_per_dropped: got %h want 7777", d_out); end
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0014) begin errors++; $display("FAIL own_per_drop_flag: got %h want 0014", d_out); end
    cpu_wr(A_CTRL, 16'h0004);
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0000) begin errors++; $display("FAIL own_drop_clear: got %h want 0000", d_out); end
  endtask

  task automatic test_timeout();
    int t_start, rise;
    cpu_wr(A_CTRL, 16'h0003);
    t_start = cyc;
    rise = -1;
    for (int i = 0; i < 20 && rise < 0; i++) begin
      idle(1);
      if (irq === 1'b1) rise = cyc;
    end
    checks++;
    if (rise != t_start + 1 + TO) begin
      errors++; $display("FAIL timeout_edge: irq rose at edge %0d want %0d", rise, t_start + 1 + TO);
    end
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h001A) begin errors++; $display("FAIL timeout_status: got %h want 001a", d_out); end
    cpu_wr(A_CTRL, 16'h0003);
    t_start = cyc;
    while (cyc + 1 < t_start + 1 + TO) idle(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL timeout_early: irq=%b want 0", irq); end
    pulse_done();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL coincide_irq: got %b want 1", irq); end
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0012) begin errors++; $display("FAIL coincide_status: got %h want 0012", d_out); end
  endtask

  task automatic test_reset_mid();
    cpu_wr(A_CTRL, 16'h0003);
    idle(2);
    rst_n = 0; idle(1); rst_n = 1;
    checks++;
    if (p_start !== 1'b0 || irq !== 1'b0 || d_out !== 16'h0000) begin
      errors++; $display("FAIL midrst_outputs: p_start=%b irq=%b d_out=%h want 0", p_start, irq, d_out);
    end
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0000) begin errors++; $display("FAIL midrst_status: got %h want 0000", d_out); end
    pulse_done();
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== 16'h0000 || irq !== 1'b0) begin
      errors++; $display("FAIL midrst_pdone_ignored: got %h irq=%b want 0000 irq=0", d_out, irq);
    end
  endtask

  function automatic logic [7:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 8'($urandom_range(0, 15));
    else if (r < 8) return A_STAT;
    else if (r == 8) return A_CTRL;
    else return 8'($urandom_range(0, 255));
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cs = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0); addr = pick_addr(); d_in = 16'($urandom());
      if (addr == A_CTRL) d_in[0] = ($urandom_range(0, 1) == 1);
      p_rd = 1'($urandom_range(0, 1)); p_wr = ($urandom_range(0, 2) == 0);
      p_addr = pick_addr(); p_d_in = 16'($urandom()); p_done = ($urandom_range(0, 5) == 0);
      tick();
      if (exp_d_ok) begin
        checks++;
        if (d_out !== exp_d) begin errors++; $display("FAIL rand_d_out @%0d: got %h want %h", cyc, d_out, exp_d); end
      end
      if (exp_pd_ok) begin
        checks++;
        if (p_d_out !== exp_pd) begin errors++; $display("FAIL rand_p_d_out @%0d: got %h want %h", cyc, p_d_out, exp_pd); end
      end
      checks++;
      if (irq !== (m_done & m_ien) || p_start !== m_pstart) begin
        errors++;
        $display("FAIL rand_ctl @%0d: irq=%b p_start=%b want irq=%b p_start=%b", cyc, irq, p_start, m_done & m_ien, m_pstart);
      end
    end
    cs = 0; rd = 0; wr = 0; p_rd = 0; p_wr = 0; p_done = 0;
    cpu_rd(A_STAT);
    checks++;
    if (d_out !== exp_d) begin errors++; $display("FAIL rand_final_status: got %h want %h", d_out, exp_d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; t0 = -100;
    m_busy = 0; m_done = 0; m_drop = 0; m_tmo = 0; m_ien = 0; m_pstart = 0;
    exp_d = 16'h0000; exp_pd = 16'h0000; exp_d_ok = 0; exp_pd_ok = 0;
    for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
    rst_n = 0; cs = 0; rd = 0; wr = 0; addr = 8'd0; d_in = 16'h0000;
    p_rd = 0; p_wr = 0; p_addr = 8'd0; p_d_in = 16'h0000; p_done = 0;
    test_reset();
    test_cpu_loop();
    test_handshake();
    test_ownership();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
